// File: rtl/rsa_rfid_if.sv
// ---------------------------------------------------------------------------
// rsa_rfid_if
// Request/response bundle between the RFID security controller and the RSA
// modular-exponentiation core.
//
//   input_text  message/base, sampled by the core on an accepted go
//   key         exponent,     sampled by the core on an accepted go
//   mod         modulus,      sampled by the core on an accepted go
//   go          start request (a one-cycle pulse is enough)
//   output_text result, valid while done is high
//   done        level, high from completion until the next accepted go
//
// Modports:
//   master  the requester (drives operands and go)
//   slave   the core      (drives output_text and done)
// ---------------------------------------------------------------------------
interface rsa_rfid_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] input_text;
   logic [WIDTH-1:0] key;
   logic [WIDTH-1:0] mod;
   logic             go;
   logic [WIDTH-1:0] output_text;
   logic             done;

   modport master (
      output input_text, key, mod, go,
      input  output_text, done
   );

   modport slave (
      input  input_text, key, mod, go,
      output output_text, done
   );
endinterface

// File: rtl/rsa_rfid_core.sv
// ---------------------------------------------------------------------------
// rsa_rfid_core
// Iterative RSA modular exponentiation: output_text = input_text^key mod mod.
// Encryption and decryption are the same operation with different key/mod.
//
// Datapath: bit-serial Blakley interleaved modular multiplier, one multiplier
// bit per clock. A REDUCE pass (base*1 mod m) brings the input below the
// modulus, then right-to-left square-and-multiply runs one exponent bit per
// WIDTH cycles, with the multiply and the square computed side by side.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; aborts any running operation
//   io     rsa_rfid_if.slave (input_text, key, mod, go / output_text, done)
//
// Parameters:
//   WIDTH  operand width (input_text, key, mod, output_text)
//
// Build option:
//   RSA_MODCHECK_EN  when defined, mod==0 and mod==1 bypass REDUCE/EXP and
//                    complete on the accepting edge with output_text=0.
//                    When undefined, mod==1 runs the normal path (result 0)
//                    and mod==0 gives an unspecified result with the normal
//                    latency.
// ---------------------------------------------------------------------------
module rsa_rfid_core #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   rsa_rfid_if.slave   io
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PW    = WIDTH + 2;   // partial product needs headroom for 2P+b < 3m

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      EXP    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] out_q;
   logic             done_q;
   logic [PW-1:0]    p_a;      // REDUCE: base*1, EXP: result*base
   logic [PW-1:0]    p_b;      // EXP: base*base
   logic [CNT_W-1:0] cnt;      // multiplier bit index, WIDTH-1 down to 0

   logic             accept;
   logic             last_bit;
   logic             e_last;
   logic             mod_trivial;
   logic [PW-1:0]    add_a;
   logic [PW-1:0]    add_b;
   logic [PW-1:0]    step_a;
   logic [PW-1:0]    step_b;
   logic [WIDTH-1:0] res_next;

   // One Blakley iteration: P = 2P + addend, then pull back below the modulus.
   // With P < m and addend < m the sum is below 3m, so two subtractions suffice.
   function automatic logic [PW-1:0] mm_step(
      input logic [PW-1:0] p,
      input logic [PW-1:0] addend,
      input logic [PW-1:0] modulus
   );
      logic [PW-1:0] t;
      t = {p[PW-2:0], 1'b0} + addend;
      if (t >= modulus) t = t - modulus;
      if (t >= modulus) t = t - modulus;
      return t;
   endfunction

`ifdef RSA_MODCHECK_EN
   assign mod_trivial = (io.mod <= WIDTH'(1));
`else
   assign mod_trivial = 1'b0;
`endif

   // Multiplier datapath and handshake decode
   always_comb begin
      last_bit = (cnt == '0);
      e_last   = ((e >> 1) == '0);
      accept   = io.go && ((state == IDLE) || (state == DONE));

      add_a = '0;
      add_b = '0;
      if (state == REDUCE) begin
         // base * 1: the multiplicand is the constant one
         if (base[cnt]) add_a = PW'(1);
      end else begin
         if (result[cnt]) add_a = {2'b00, base};
      end
      if (base[cnt]) add_b = {2'b00, base};

      step_a   = mm_step(p_a, add_a, {2'b00, m});
      step_b   = mm_step(p_b, add_b, {2'b00, m});
      res_next = e[0] ? step_a[WIDTH-1:0] : result;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (accept) state_next = mod_trivial ? DONE : REDUCE;
         end
         REDUCE: begin
            // key==0 never enters EXP
            if (last_bit) state_next = (e == '0) ? DONE : EXP;
         end
         EXP: begin
            if (last_bit && e_last) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Operand, accumulator and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base   <= '0;
         e      <= '0;
         m      <= '0;
         result <= '0;
         out_q  <= '0;
         done_q <= 1'b0;
         p_a    <= '0;
         p_b    <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  base   <= io.input_text;
                  e      <= io.key;
                  m      <= io.mod;
                  result <= (io.mod == WIDTH'(1)) ? '0 : WIDTH'(1);
                  p_a    <= '0;
                  p_b    <= '0;
                  cnt    <= CNT_W'(WIDTH - 1);
                  if (mod_trivial) begin
                     out_q  <= '0;
                     done_q <= 1'b1;
                  end else begin
                     done_q <= 1'b0;   // out_q keeps the previous result while busy
                  end
               end
            end

            REDUCE: begin
               if (last_bit) begin
                  base <= step_a[WIDTH-1:0];
                  p_a  <= '0;
                  cnt  <= CNT_W'(WIDTH - 1);
                  if (e == '0) begin
                     out_q  <= result;
                     done_q <= 1'b1;
                  end
               end else begin
                  p_a <= step_a;
                  cnt <= cnt - 1'b1;
               end
            end

            EXP: begin
               if (last_bit) begin
                  // Both products used the old base/result; commit together
                  result <= res_next;
                  base   <= step_b[WIDTH-1:0];
                  e      <= e >> 1;
                  p_a    <= '0;
                  p_b    <= '0;
                  cnt    <= CNT_W'(WIDTH - 1);
                  if (e_last) begin
                     out_q  <= res_next;
                     done_q <= 1'b1;
                  end
               end else begin
                  p_a <= step_a;
                  p_b <= step_b;
                  cnt <= cnt - 1'b1;
               end
            end

            default: begin
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign io.output_text = out_q;
   assign io.done        = done_q;

endmodule

// File: tb/tb_rsa_rfid_core.sv
// ---------------------------------------------------------------------------
// tb_rsa_rfid_core
// Scoreboard bench for rsa_rfid_core: the driver pushes the reference result
// of every issued operation, a monitor pops and compares on each rising edge
// of done. The reference is plain 64-bit modular arithmetic.
// ---------------------------------------------------------------------------
module tb_rsa_rfid_core;

   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   rsa_rfid_if #(.WIDTH(W)) io ();

   rsa_rfid_core #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] prev_out;
   logic         done_prev = 1'b0;

   // Left-to-right exponentiation using ordinary % on 64-bit values
   function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b,
                                            input logic [W-1:0] k,
                                            input logic [W-1:0] m);
      longint unsigned r, bb, mm;
      mm = {32'd0, m};
      bb = {32'd0, b} % mm;
      r  = 64'd1 % mm;
      for (int i = W - 1; i >= 0; i--) begin
         r = (r * r) % mm;
         if (k[i]) r = (r * bb) % mm;
      end
      return r[W-1:0];
   endfunction

   function automatic int bitlen(input logic [W-1:0] k);
      int n;
      n = 0;
      for (int i = 0; i < W; i++) if (k[i]) n = i + 1;
      return n;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: every rising edge of done must match the oldest expectation
   always @(negedge clk) begin
      if (io.done === 1'b1 && done_prev === 1'b0) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=%0d required=none", io.output_text);
         end else begin
            check("result", io.output_text, exp_q.pop_front());
         end
      end
      done_prev <= io.done;
   end

   task automatic run_op(input logic [W-1:0] in, input logic [W-1:0] k,
                         input logic [W-1:0] m, input bit busy_go);
      logic [W-1:0] expv;
      int cyc, bound;
      expv = ref_pow(in, k, m);
      @(negedge clk);
      io.input_text = in;
      io.key        = k;
      io.mod        = m;
      io.go         = 1'b1;
      exp_q.push_back(expv);
      @(negedge clk);
      io.go = 1'b0;
      check("done_cleared", {31'd0, io.done}, 0);
      check("out_held_busy", io.output_text, prev_out);
      bound = W * (1 + bitlen(k)) + 2;
      cyc   = 0;
      while (io.done !== 1'b1 && cyc <= bound) begin
         if (busy_go && cyc == 3) begin
            io.input_text = $urandom;
            io.key        = $urandom;
            io.mod        = $urandom | 32'd1;
            io.go         = 1'b1;
         end else begin
            io.go = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      io.go = 1'b0;
      checks++;
      if (io.done !== 1'b1 || cyc > bound) begin
         failures++;
         $display("FAIL latency actual=%0d required<=%0d", cyc, bound);
         exp_q.delete();
      end
      prev_out = expv;
      repeat (2) @(negedge clk);
      check("done_hold", {31'd0, io.done}, 1);
      check("out_stable", io.output_text, expv);
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] ri, rk, rm;
      reset         = 1'b1;
      io.go         = 1'b0;
      io.input_text = '0;
      io.key        = '0;
      io.mod        = '0;
      prev_out      = '0;
      repeat (3) @(negedge clk);
      check("reset_done", {31'd0, io.done}, 0);
      check("reset_out", io.output_text, 0);
      reset = 1'b0;

      run_op(32'd4, 32'd13, 32'd497, 1'b0);
      check("vec_4_13_497", io.output_text, 445);
      run_op(32'd5, 32'd3, 32'd13, 1'b1);
      check("vec_busy_go", io.output_text, 8);
      run_op(32'd5, 32'd65537, 32'd36349, 1'b0);
      run_op(32'd7, 32'd0, 32'd11, 1'b0);
      check("vec_key0", io.output_text, 1);
      run_op(32'd1000, 32'd1, 32'd37, 1'b0);
      check("vec_reduce", io.output_text, 1);
      run_op(32'd9, 32'd5, 32'd1, 1'b0);
      check("vec_mod1", io.output_text, 0);

      for (int n = 0; n < 16; n++) begin
         ri = $urandom;
         rk = $urandom >> $urandom_range(0, 31);
         case ($urandom_range(0, 3))
            0:       rm = 32'd1;
            1:       rm = $urandom_range(2, 65535);
            default: rm = $urandom;
         endcase
         if (rm == 0) rm = 32'd1;
         run_op(ri, rk, rm, n[0]);
      end

      // Abort in the middle of EXP; the previous result is nonzero
      run_op(32'd3, 32'd5, 32'd1009, 1'b0);
      @(negedge clk);
      io.input_text = 32'd3;
      io.key        = 32'hFFFF;
      io.mod        = 32'd1009;
      io.go         = 1'b1;
      @(negedge clk);
      io.go = 1'b0;
      repeat (100) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_done", {31'd0, io.done}, 0);
      check("abort_out", io.output_text, 0);
      exp_q.delete();
      prev_out = '0;
      @(negedge clk);
      reset = 1'b0;

      run_op(32'd2, 32'd10, 32'd1000, 1'b0);
      check("vec_after_reset", io.output_text, 24);

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
